// File: rtl/hazard_pkg.sv
// Shared types and sizing helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_NUM_W = 5;
    localparam int STAT_W    = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    // Width of the wait counter; always at least one bit so a disabled timeout still elaborates.
    function automatic int cnt_w(input int t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// RAW match of one ID source register against the EX, MEM and WB destinations.
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [REG_NUM_W-1:0] src_i,
    input  logic                 use_i,
    input  logic [REG_NUM_W-1:0] ex_rd_i,
    input  logic                 ex_we_i,
    input  logic [REG_NUM_W-1:0] mem_rd_i,
    input  logic                 mem_we_i,
    input  logic [REG_NUM_W-1:0] wb_rd_i,
    input  logic                 wb_we_i,
    output logic                 match_o
);

    logic live;

    // Register 0 is hardwired, so it never creates a dependency.
    assign live    = use_i && (src_i != '0);
    assign match_o = live && ((ex_we_i  && (src_i == ex_rd_i))  ||
                              (mem_we_i && (src_i == mem_rd_i)) ||
                              (wb_we_i  && (src_i == wb_rd_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush/freeze sequencing for the 5-stage pipeline (no forwarding).
// Optional HAZARD_STATS_EN adds saturating stall/flush/wait counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [REG_NUM_W-1:0] id_rs,
    input  logic [REG_NUM_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [REG_NUM_W-1:0] ex_rd,
    input  logic [REG_NUM_W-1:0] mem_rd,
    input  logic [REG_NUM_W-1:0] wb_rd,
    input  logic                 ex_we,
    input  logic                 mem_we,
    input  logic                 wb_we,
    input  logic                 mem_redirect,
    input  logic                 mem_access,
    input  logic                 mem_ready,
    input  logic                 halted,
    output logic                 pc_we,
    output logic                 if_id_hold,
    output logic                 id_ex_bubble,
    output logic                 flush,
    output logic                 freeze,
    output logic                 mem_timeout,
    output logic [1:0]           state
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_stall_cycles,
    output logic [STAT_W-1:0]    stat_flushes,
    output logic [STAT_W-1:0]    stat_wait_cycles
`endif
);

    localparam int            CW      = cnt_w(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TMO     = CW'(MEM_TIMEOUT);

    logic [1:0]    state_q, state_d, cur;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          haz_rs, haz_rt, hazard;
    logic          tail, wait_cyc;

    hazard_cmp u_cmp_rs (
        .src_i   (id_rs),
        .use_i   (id_uses_rs),
        .ex_rd_i (ex_rd),
        .ex_we_i (ex_we),
        .mem_rd_i(mem_rd),
        .mem_we_i(mem_we),
        .wb_rd_i (wb_rd),
        .wb_we_i (wb_we),
        .match_o (haz_rs)
    );

    hazard_cmp u_cmp_rt (
        .src_i   (id_rt),
        .use_i   (id_uses_rt),
        .ex_rd_i (ex_rd),
        .ex_we_i (ex_we),
        .mem_rd_i(mem_rd),
        .mem_we_i(mem_we),
        .wb_rd_i (wb_rd),
        .wb_we_i (wb_we),
        .match_o (haz_rt)
    );

    assign hazard = haz_rs || haz_rt;
    // While in reset the controls follow RUN rules so the PC keeps loading.
    assign cur    = rst_b ? 2'(RUN) : state_q;

    always_comb begin
        pc_we        = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        flush        = 1'b0;
        freeze       = 1'b0;
        tail         = 1'b0;
        wait_cyc     = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;

        case (cur)
            RUN: begin
                if (halted) begin
                    freeze  = 1'b1;
                    state_d = HALT;
                end else if (mem_access && !mem_ready) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end else begin
                    tail    = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze   = 1'b1;
                    wait_cyc = 1'b1;
                    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (MEM_TIMEOUT != 0 && cnt_d >= TMO) tmo_d = 1'b1;
                end else begin
                    tail    = 1'b1;
                    state_d = RUN;
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                freeze  = 1'b1;
                state_d = RUN;
            end
        endcase

        // A redirect squashes the ID instruction, so its hazard is moot.
        if (tail) begin
            if (mem_redirect) begin
                flush = 1'b1;
                pc_we = 1'b1;
            end else if (hazard) begin
                if_id_hold   = 1'b1;
                id_ex_bubble = 1'b1;
            end else begin
                pc_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= RUN;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_timeout = tmo_q;
    assign state       = state_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] sst_q, sfl_q, swt_q;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            sst_q <= '0;
            sfl_q <= '0;
            swt_q <= '0;
        end else begin
            if (id_ex_bubble && sst_q != '1) sst_q <= sst_q + 1'b1;
            if (flush && sfl_q != '1)        sfl_q <= sfl_q + 1'b1;
            if (wait_cyc && swt_q != '1)     swt_q <= swt_q + 1'b1;
        end
    end

    assign stat_stall_cycles = sst_q;
    assign stat_flushes      = sfl_q;
    assign stat_wait_cycles  = swt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: driver predicts each cycle's controls from the hazard rules,
// a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam int T = 3;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, ex_we, mem_we, wb_we;
    logic       mem_redirect, mem_access, mem_ready, halted;
    logic       pc_we, if_id_hold, id_ex_bubble, flush, freeze, mem_timeout;
    logic [1:0] state;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_stall_cycles, stat_flushes, stat_wait_cycles;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_b(rst_b),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .mem_redirect(mem_redirect), .mem_access(mem_access), .mem_ready(mem_ready),
        .halted(halted),
        .pc_we(pc_we), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
        .flush(flush), .freeze(freeze), .mem_timeout(mem_timeout), .state(state)
`ifdef HAZARD_STATS_EN
        , .stat_stall_cycles(stat_stall_cycles), .stat_flushes(stat_flushes),
        .stat_wait_cycles(stat_wait_cycles)
`endif
    );

    typedef struct {
        logic [7:0] ctl;  // {pc_we, hold, bubble, flush, freeze, timeout, state}
        int         sst, sfl, swt;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;

    // Reference machine: mode 0=running, 1=waiting on cache, 2=halted.
    int   m_mode = 0, m_waits = 0, m_sst = 0, m_sfl = 0, m_swt = 0;
    bit   m_tmo = 0;

    function automatic bit reads_inflight(input bit use_src, input logic [4:0] r);
        logic [4:0] rds [3];
        bit         wes [3];
        rds = '{ex_rd, mem_rd, wb_rd};
        wes = '{ex_we, mem_we, wb_we};
        if (!use_src || r == 0) return 0;
        foreach (rds[k]) if (wes[k] && rds[k] == r) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        {id_rs, id_rt, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs, id_uses_rt, ex_we, mem_we, wb_we} = '0;
        {mem_redirect, mem_access, mem_ready, halted} = '0;
    endtask

    // Predict this cycle's outputs, push them, then advance the model across the edge.
    task automatic cyc();
        exp_t e;
        bit   p_pc = 0, p_hold = 0, p_bub = 0, p_fl = 0, p_fz = 0;
        bit   normal = 0, waiting = 0, enter_wait = 0;
        int   mode_now = rst_b ? 0 : m_mode;
        int   nxt = mode_now;
        bit   stall = reads_inflight(id_uses_rs, id_rs) || reads_inflight(id_uses_rt, id_rt);

        if (mode_now == 0) begin
            if (halted)                        begin p_fz = 1; nxt = 2; end
            else if (mem_access && !mem_ready) begin p_fz = 1; nxt = 1; enter_wait = 1; end
            else normal = 1;
        end else if (mode_now == 1) begin
            if (!mem_ready) begin p_fz = 1; waiting = 1; end
            else begin normal = 1; nxt = 0; end
        end else begin
            p_fz = 1;
        end
        if (normal) begin
            if (mem_redirect) begin p_fl = 1; p_pc = 1; end
            else if (stall)   begin p_hold = 1; p_bub = 1; end
            else p_pc = 1;
        end

        e.ctl = {p_pc, p_hold, p_bub, p_fl, p_fz, m_tmo, 2'(m_mode)};
        e.sst = m_sst; e.sfl = m_sfl; e.swt = m_swt;
        q.push_back(e);

        @(posedge clk);
        if (rst_b) begin
            m_mode = 0; m_waits = 0; m_tmo = 0; m_sst = 0; m_sfl = 0; m_swt = 0;
        end else begin
            m_sst += p_bub; m_sfl += p_fl; m_swt += waiting;
            if (enter_wait) m_waits = 0;
            if (waiting) begin
                m_waits++;
                if (T != 0 && m_waits >= T) m_tmo = 1;
            end
            m_mode = nxt;
        end
        #1;
    endtask

    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_we, if_id_hold, id_ex_bubble, flush, freeze, mem_timeout, state};
                tests++;
                if (act !== e.ctl) begin
                    fails++;
                    $display("FAIL ctl @%0t: got pc/hold/bub/fl/fz/tmo/st=%b want %b", $time, act, e.ctl);
                end
`ifdef HAZARD_STATS_EN
                tests++;
                if (stat_stall_cycles !== 32'(e.sst) || stat_flushes !== 32'(e.sfl) ||
                    stat_wait_cycles !== 32'(e.swt)) begin
                    fails++;
                    $display("FAIL stats @%0t: got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                             stat_stall_cycles, stat_flushes, stat_wait_cycles, e.sst, e.sfl, e.swt);
                end
`endif
            end
        end
    end

    initial begin
        clear_inputs();
        rst_b = 1'b1;
        @(posedge clk); #1;
        cyc();                      // reset, idle inputs: PC advances, state RUN
        rst_b = 1'b0;

        // EX producer advancing to WB: 3 stall cycles then release
        id_rs = 5; id_uses_rs = 1; ex_rd = 5; ex_we = 1;  cyc();
        ex_we = 0; mem_rd = 5; mem_we = 1;                cyc();
        mem_we = 0; wb_rd = 5; wb_we = 1;                 cyc();
        wb_we = 0;                                        cyc();
        clear_inputs();

        // r0 never stalls
        id_rt = 0; id_uses_rt = 1; ex_rd = 0; ex_we = 1;  cyc();
        clear_inputs();

        // 4-cycle miss then ready
        mem_access = 1; mem_ready = 0;
        repeat (4) cyc();
        mem_ready = 1;                                    cyc();
        clear_inputs();
        rst_b = 1; cyc(); rst_b = 0;

        // redirect beats hazard
        id_rs = 7; id_uses_rs = 1; mem_rd = 7; mem_we = 1; mem_redirect = 1; cyc();
        // redirect during a miss is deferred to the ready cycle
        mem_access = 1; mem_ready = 0; cyc(); cyc();
        mem_ready = 1; cyc();
        clear_inputs();

        // halt is sticky, reset releases it
        halted = 1; repeat (3) cyc();
        halted = 0; repeat (2) cyc();
        rst_b = 1; cyc(); rst_b = 0;
        cyc();

        // timeout with ready held low
        mem_access = 1; mem_ready = 0;
        repeat (7) cyc();
        mem_ready = 1; cyc();
        clear_inputs(); cyc();
        rst_b = 1; cyc(); rst_b = 0;

        for (int i = 0; i < 3000; i++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            wb_rd        = 5'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom_range(0, 1));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_we        = 1'($urandom_range(0, 1));
            mem_we       = 1'($urandom_range(0, 1));
            wb_we        = 1'($urandom_range(0, 1));
            mem_redirect = ($urandom_range(0, 99) < 15);
            mem_access   = ($urandom_range(0, 99) < 30);
            mem_ready    = ($urandom_range(0, 99) < 45);
            halted       = ($urandom_range(0, 99) < 2);
            rst_b        = ($urandom_range(0, 99) < 3);
            cyc();
        end
        rst_b = 0;
        clear_inputs();

        repeat (3) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
